// File: rtl/add_operand_sequencer.sv
// Serial A/B operand loader around an external combinational adder; registers the
// sum with locally derived carry/overflow flags and offers it on a valid/ready stream.
module add_operand_sequencer #(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   op_a,
   output logic [WIDTH-1:0]   op_b,
   input  logic [WIDTH-1:0]   sum,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_carry,
   output logic               out_ovf,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic [COUNT_W-1:0] add_count
);

   // state  | meaning
   // LOAD_A | waiting for operand A
   // LOAD_B | A held, waiting for operand B
   // ADD    | adder settling on op_a/op_b, result captured at next edge
   // HOLD   | result presented until out_ready
   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      ADD    = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  a_reg, b_reg;
   logic              load_a, load_b, do_add, release_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD_A;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      in_ready    = 1'b0;
      busy        = 1'b1;
      load_a      = 1'b0;
      load_b      = 1'b0;
      do_add      = 1'b0;
      release_out = 1'b0;
      case (state)
         LOAD_A: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               load_a    = 1'b1;
               state_nxt = LOAD_B;
            end
         end
         LOAD_B: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_b    = 1'b1;
               state_nxt = ADD;
            end
         end
         ADD: begin
            do_add    = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               release_out = 1'b1;
               state_nxt   = LOAD_A;
            end
         end
         default: state_nxt = LOAD_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
      end else begin
         if (load_a) a_reg <= in_data;
         if (load_b) b_reg <= in_data;
      end
   end

   // Flags come from the registered operands since the adder has no carry-out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_carry <= 1'b0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
         add_count <= '0;
      end else if (do_add) begin
         out_data  <= sum;
         out_carry <= (sum < a_reg);
         out_ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
         out_valid <= 1'b1;
         add_count <= add_count + 1'b1;
      end else if (release_out) begin
         out_valid <= 1'b0;
      end
   end

   assign op_a = a_reg;
   assign op_b = b_reg;

endmodule
